// File: rtl/csa_stream_accum.sv
// Streaming multi-operand accumulator: beats are folded into redundant (sum, carry)
// registers with 3:2 compressors, and one carry-propagate add resolves each frame.
module csa_stream_accum #(
    parameter int W      = 16,
    parameter int NIN    = 3,
    parameter int GUARD  = 8,
    parameter int SIGNED = 0,
    parameter int ACC_W  = W + $clog2(NIN) + GUARD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NIN*W-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [GUARD:0]     out_beats,
    output logic               out_overflow
);
    localparam int CNT_W = GUARD + 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(1 << GUARD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << GUARD) + 1);

    typedef enum logic [1:0] {INIT, ACCUM, RESOLVE, OUTPUT} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d, c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_beats_q, out_beats_d;
    logic               out_overflow_q, out_overflow_d;

    logic [ACC_W-1:0]   tree_s, tree_c, next_s, next_c, op;
    logic               accept;

    // Chain of 3:2 compressors: each operand is folded into the running (sum, carry) pair.
    always_comb begin
        tree_s = s_q;
        tree_c = c_q;
        next_s = '0;
        next_c = '0;
        op     = '0;
        for (int k = 0; k < NIN; k++) begin
            if (SIGNED != 0) begin
                op = ACC_W'($signed(in_data[k*W +: W]));
            end else begin
                op = ACC_W'(in_data[k*W +: W]);
            end
            next_s = tree_s ^ tree_c ^ op;
            next_c = ((tree_s & tree_c) | (tree_s & op) | (tree_c & op)) << 1;
            tree_s = next_s;
            tree_c = next_c;
        end
    end

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d        = state_q;
        s_d            = s_q;
        c_d            = c_q;
        cnt_d          = cnt_q;
        out_valid_d    = out_valid_q;
        out_sum_d      = out_sum_q;
        out_beats_d    = out_beats_q;
        out_overflow_d = out_overflow_q;
        case (state_q)
            INIT: begin
                state_d = ACCUM;
            end
            ACCUM: begin
                if (accept) begin
                    s_d = tree_s;
                    c_d = tree_c;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_sum_d      = s_q + c_q;
                out_beats_d    = cnt_q;
                out_overflow_d = (cnt_q > CNT_LIM);
                out_valid_d    = 1'b1;
                state_d        = OUTPUT;
            end
            OUTPUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    s_d         = '0;
                    c_d         = '0;
                    cnt_d       = '0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
        // in_ready is registered, so it tracks the state being entered.
        in_ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= INIT;
            s_q            <= '0;
            c_q            <= '0;
            cnt_q          <= '0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_beats_q    <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            s_q            <= s_d;
            c_q            <= c_d;
            cnt_q          <= cnt_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_sum_q      <= out_sum_d;
            out_beats_q    <= out_beats_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_beats    = out_beats_q;
    assign out_overflow = out_overflow_q;
endmodule
